fifo_nic2noc: RTL and testbench
===============================

// Module: fifo_nic2noc
// PURPOSE
// NiC output stage between the fifo_out_buffers and the router input port. Keeps one
// pointer slot per downstream VC: which fifo_out_buffer owns the VC, and whether the VC
// is busy. Routes router credits back to the owning fifo_out_buffer and registers the
// outgoing flit onto the link. Reports free VCs to the vc_allocator.
// PARAMETERS
// N_TOT_OF_VC             6  number of downstream VCs (vnets * `N_OF_VC)
// N_FIFO_OUT_BUFFER       6  number of fifo_out_buffers upstream
// N_BITS_FIFO_OUT_BUFFER  3  width of a fifo_out_buffer id; 2**N >= N_FIFO_OUT_BUFFER
// PORTS
// clk                     in   1                          clock
// rst                     in   1                          asynchronous reset, active-low
// g_fifo_pointer_i        in   N_TOT_OF_VC                bit i: VC i allocated this cycle
// g_fifo_out_buffer_id_i  in   N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER  owner id per VC, slice i
// release_pointer_i       in   N_TOT_OF_VC                bit i: VC i returns to idle
// credit_in_i             in   N_TOT_OF_VC                credit pulse from router, per VC
// credit_signal_o         out  N_TOT_OF_VC                credit forwarded to owning buffer
// fifo_pointed_o          out  N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER  owner id per VC, slice i
// vc_free_o               out  N_TOT_OF_VC                bit i: VC i idle, allocatable
// flit_i                  in   `FLIT_WIDTH                flit from winning fifo_out_buffer
// is_valid_i              in   1                          flit_i valid
// flit_o                  out  `FLIT_WIDTH                flit to router link
// is_valid_o              out  1                          flit_o valid
// err_o                   out  1                          sticky protocol-violation flag
// BEHAVIOUR
// - Reset (rst==0, async): all slots IDLE, owner=0; vc_free_o=all ones; credit_signal_o=0;
//   fifo_pointed_o=0; flit_o=0; is_valid_o=0; err_o=0.
// - Per-slot FSM, states IDLE/BUSY, updated on posedge clk:
//   IDLE --g_fifo_pointer_i[i]--> BUSY, owner <= slice i of g_fifo_out_buffer_id_i.
//   BUSY --release_pointer_i[i] & !g_fifo_pointer_i[i]--> IDLE, owner is held.
//   BUSY & g_fifo_pointer_i[i] & release_pointer_i[i] -> stays BUSY, owner <= new id.
//   This is release of the old owner and back-to-back reallocation.
//   BUSY & g_fifo_pointer_i[i] & !release_pointer_i[i] -> grant ignored, err_o <= 1.
//   IDLE & release_pointer_i[i] -> ignored, err_o <= 1.
// - vc_free_o[i] = (state==IDLE), registered from the FSM. A grant becomes visible as
//   not-free the cycle after it arrives.
// - Credit path, 1-cycle latency:
//   credit_signal_o[i] <= credit_in_i[i] & (state==BUSY).
//   Slice i of fifo_pointed_o <= owner at the moment of sampling.
//   A credit and a release in the same cycle are forwarded to the old owner.
//   A credit on an IDLE slot is dropped and sets err_o.
//   A credit in the same cycle as a reallocation goes to the old owner.
// - Flit path, 1-cycle register: flit_o <= flit_i; is_valid_o <= is_valid_i.
//   flit_o is held when is_valid_i==0. No backpressure; credits upstream already
//   guarantee router space.
// - err_o is cleared only by reset.
// - Several slots may change in the same cycle, independently.
// - Reset mid-packet drops all ownership. No credits are emitted after reset.
// STRUCTURE
// - NIC-defines.v provides `FLIT_WIDTH and `N_OF_VC. Add localparams VC_IDLE=1'b0 and
//   VC_BUSY=1'b1 there.
// - Sub-module nic2noc_vc_slot: one VC's FSM, owner register and credit register.
//   It emits an error pulse. The top generates N_TOT_OF_VC slots, ORs the error pulses
//   into err_o, and holds the flit register.
// TESTING
// 1. Reset, then idle -> vc_free_o=6'b111111, is_valid_o=0, err_o=0.
// 2. g_fifo_pointer_i=6'b000100 with slice 2 id=3, then credit_in_i[2] two cycles later
//    -> vc_free_o[2]=0 next cycle; credit_signal_o=6'b000100 and fifo_pointed_o slice 2=3,
//    one cycle after the credit.
// 3. VC2 BUSY owner 3: release and credit together -> credit to id 3, vc_free_o[2]=1 next
//    cycle. A further credit on VC2 -> dropped, err_o=1.
// 4. VC0 BUSY owner 1: grant (id 5) and release same cycle -> stays BUSY, owner=5.
//    Next credit -> fifo_pointed_o slice 0=5.
// 5. Flit stream: 0xA5.., 0x5A.. on consecutive cycles, then a gap -> identical values
//    with 1-cycle delay; is_valid_o drops in the gap.
// 6. Assert rst low asynchronously while VC1 and VC4 are BUSY -> outputs reset at once,
//    before the clock edge. All VCs free after rst is released.

Source files
------------

// File: rtl/fifo_nic2noc_pkg.sv
// Shared constants and types for the NiC-to-NoC output stage.
package fifo_nic2noc_pkg;

    localparam int unsigned FLIT_WIDTH             = 32;
    localparam int unsigned N_VNETS                = 2;
    localparam int unsigned N_OF_VC                = 3;
    localparam int unsigned N_TOT_OF_VC            = N_VNETS * N_OF_VC;
    localparam int unsigned N_FIFO_OUT_BUFFER      = 6;
    localparam int unsigned N_BITS_FIFO_OUT_BUFFER = 3;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_e;

endpackage

// File: rtl/nic2noc_vc_slot.sv
// One downstream VC: ownership FSM, owner register and registered credit forwarding.
module nic2noc_vc_slot
    import fifo_nic2noc_pkg::*;
#(
    parameter int unsigned ID_W = N_BITS_FIFO_OUT_BUFFER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            grant,
    input  logic [ID_W-1:0] grant_id,
    input  logic            release_ptr,
    input  logic            credit_in,
    output logic            vc_free,
    output logic            credit_out,
    output logic [ID_W-1:0] owner_out,
    output logic            err_pulse
);

    vc_state_e       state_q;
    logic [ID_W-1:0] owner_q;

    always_comb begin
        err_pulse = 1'b0;
        if (state_q == VC_BUSY) begin
            err_pulse = grant & ~release_ptr;
        end else begin
            err_pulse = release_ptr | credit_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= VC_IDLE;
            owner_q    <= '0;
            vc_free    <= 1'b1;
            credit_out <= 1'b0;
            owner_out  <= '0;
        end else begin
            // Credit and owner are sampled before this edge's ownership change.
            credit_out <= credit_in & (state_q == VC_BUSY);
            owner_out  <= owner_q;
            case (state_q)
                VC_IDLE: begin
                    if (grant) begin
                        state_q <= VC_BUSY;
                        owner_q <= grant_id;
                        vc_free <= 1'b0;
                    end
                end
                VC_BUSY: begin
                    if (release_ptr) begin
                        if (grant) begin
                            owner_q <= grant_id;
                        end else begin
                            state_q <= VC_IDLE;
                            vc_free <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_nic2noc.sv
// NiC output stage: per-VC ownership slots, credit return routing and the link flit register.
module fifo_nic2noc
    import fifo_nic2noc_pkg::*;
#(
    parameter int unsigned N_TOT = N_TOT_OF_VC,
    parameter int unsigned N_FOB = N_FIFO_OUT_BUFFER,
    parameter int unsigned ID_W  = N_BITS_FIFO_OUT_BUFFER,
    parameter int unsigned FW    = FLIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_TOT-1:0]      g_fifo_pointer_i,
    input  logic [N_TOT*ID_W-1:0] g_fifo_out_buffer_id_i,
    input  logic [N_TOT-1:0]      release_pointer_i,
    input  logic [N_TOT-1:0]      credit_in_i,
    output logic [N_TOT-1:0]      credit_signal_o,
    output logic [N_TOT*ID_W-1:0] fifo_pointed_o,
    output logic [N_TOT-1:0]      vc_free_o,
    input  logic [FW-1:0]         flit_i,
    input  logic                  is_valid_i,
    output logic [FW-1:0]         flit_o,
    output logic                  is_valid_o,
    output logic                  err_o
);

    if ((2 ** ID_W) < N_FOB) begin : g_bad_id_width
        $error("ID_W too narrow for N_FOB fifo_out_buffers");
    end

    logic [N_TOT-1:0] err_pulse;

    for (genvar i = 0; i < N_TOT; i++) begin : g_slot
        nic2noc_vc_slot #(
            .ID_W(ID_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .grant      (g_fifo_pointer_i[i]),
            .grant_id   (g_fifo_out_buffer_id_i[i*ID_W +: ID_W]),
            .release_ptr(release_pointer_i[i]),
            .credit_in  (credit_in_i[i]),
            .vc_free    (vc_free_o[i]),
            .credit_out (credit_signal_o[i]),
            .owner_out  (fifo_pointed_o[i*ID_W +: ID_W]),
            .err_pulse  (err_pulse[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_o     <= '0;
            is_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            if (is_valid_i) begin
                flit_o <= flit_i;
            end
            is_valid_o <= is_valid_i;
            err_o      <= err_o | (|err_pulse);
        end
    end

endmodule

// File: tb/tb_fifo_nic2noc.sv
// Self-checking bench for fifo_nic2noc: directed scenarios plus randomized traffic vs a model.
module tb_fifo_nic2noc;

    localparam int N  = 6;
    localparam int W  = 3;
    localparam int FW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    g_ptr;
    logic [N*W-1:0]  g_id;
    logic [N-1:0]    rel;
    logic [N-1:0]    cin;
    logic [N-1:0]    credit_signal_o;
    logic [N*W-1:0]  fifo_pointed_o;
    logic [N-1:0]    vc_free_o;
    logic [FW-1:0]   flit_in;
    logic            vin;
    logic [FW-1:0]   flit_o;
    logic            is_valid_o;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: per-VC ownership table plus expected registered outputs.
    bit              m_busy [N];
    logic [W-1:0]    m_owner[N];
    logic            m_err;
    logic [N-1:0]    e_credit;
    logic [N-1:0]    e_free;
    logic [W-1:0]    e_ptd  [N];
    logic [FW-1:0]   e_flit;
    logic            e_valid;

    fifo_nic2noc dut (
        .clk                   (clk),
        .rst                   (rst),
        .g_fifo_pointer_i      (g_ptr),
        .g_fifo_out_buffer_id_i(g_id),
        .release_pointer_i     (rel),
        .credit_in_i           (cin),
        .credit_signal_o       (credit_signal_o),
        .fifo_pointed_o        (fifo_pointed_o),
        .vc_free_o             (vc_free_o),
        .flit_i                (flit_in),
        .is_valid_i            (vin),
        .flit_o                (flit_o),
        .is_valid_o            (is_valid_o),
        .err_o                 (err_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        g_ptr = '0; g_id = '0; rel = '0; cin = '0; vin = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_owner[i] = '0; e_ptd[i] = '0;
        end
        m_err = 1'b0; e_credit = '0; e_free = '1; e_flit = '0; e_valid = 1'b0;
    endtask

    // Advance model with the current inputs, then clock the DUT and settle.
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] id;
            id = g_id[i*W +: W];
            e_credit[i] = cin[i] && m_busy[i];
            e_ptd[i]    = m_owner[i];
            if (m_busy[i] && g_ptr[i] && !rel[i]) m_err = 1'b1;
            if (!m_busy[i] && (rel[i] || cin[i])) m_err = 1'b1;
            if (!m_busy[i]) begin
                if (g_ptr[i]) begin m_busy[i] = 1; m_owner[i] = id; end
            end else if (rel[i]) begin
                if (g_ptr[i]) m_owner[i] = id;
                else m_busy[i] = 0;
            end
            e_free[i] = !m_busy[i];
        end
        if (vin) e_flit = flit_in;
        e_valid = vin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        flit_in = '0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        checks++; if (vc_free_o !== 6'b111111) begin errors++;
            $display("FAIL reset_free got %b want 111111", vc_free_o); end
        checks++; if (is_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", is_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b want 0", err_o); end
        checks++; if (credit_signal_o !== 6'b0) begin errors++;
            $display("FAIL reset_credit got %b want 0", credit_signal_o); end
        checks++; if (fifo_pointed_o !== '0) begin errors++;
            $display("FAIL reset_pointed got %h want 0", fifo_pointed_o); end
    endtask

    task automatic test_grant_credit();
        g_ptr = 6'b000100; g_id = 18'(3) << 6;
        tick();
        clear_inputs();
        checks++; if (vc_free_o !== 6'b111011) begin errors++;
            $display("FAIL grant_free got %b want 111011", vc_free_o); end
        tick();
        cin = 6'b000100;
        tick();
        clear_inputs();
        checks++; if (credit_signal_o !== 6'b000100) begin errors++;
            $display("FAIL grant_credit got %b want 000100", credit_signal_o); end
        checks++; if (fifo_pointed_o[8:6] !== 3'd3) begin errors++;
            $display("FAIL grant_pointed got %0d want 3", fifo_pointed_o[8:6]); end
        checks++; if (err_o !== 1'b0) begin errors++;
            $display("FAIL grant_err got %b want 0", err_o); end
    endtask

    task automatic test_release_credit();
        rel = 6'b000100; cin = 6'b000100;
        tick();
        clear_inputs();
        checks++; if (credit_signal_o !== 6'b000100) begin errors++;
            $display("FAIL rel_credit got %b want 000100", credit_signal_o); end
        checks++; if (fifo_pointed_o[8:6] !== 3'd3) begin errors++;
            $display("FAIL rel_pointed got %0d want 3", fifo_pointed_o[8:6]); end
        checks++; if (vc_free_o !== 6'b111111) begin errors++;
            $display("FAIL rel_free got %b want 111111", vc_free_o); end
        cin = 6'b000100;
        tick();
        clear_inputs();
        checks++; if (credit_signal_o !== 6'b0) begin errors++;
            $display("FAIL idle_credit_drop got %b want 0", credit_signal_o); end
        checks++; if (err_o !== 1'b1) begin errors++;
            $display("FAIL idle_credit_err got %b want 1", err_o); end
    endtask

    task automatic test_realloc();
        g_ptr = 6'b000001; g_id = 18'(1);
        tick();
        g_ptr = 6'b000001; rel = 6'b000001; g_id = 18'(5);
        tick();
        clear_inputs();
        checks++; if (vc_free_o[0] !== 1'b0) begin errors++;
            $display("FAIL realloc_free got %b want 0", vc_free_o[0]); end
        cin = 6'b000001;
        tick();
        clear_inputs();
        checks++; if (credit_signal_o !== 6'b000001) begin errors++;
            $display("FAIL realloc_credit got %b want 000001", credit_signal_o); end
        checks++; if (fifo_pointed_o[2:0] !== 3'd5) begin errors++;
            $display("FAIL realloc_pointed got %0d want 5", fifo_pointed_o[2:0]); end
    endtask

    task automatic test_flit();
        vin = 1'b1; flit_in = 32'hA5A5_A5A5;
        tick();
        checks++; if (flit_o !== 32'hA5A5_A5A5 || is_valid_o !== 1'b1) begin errors++;
            $display("FAIL flit0 got %h/%b want a5a5a5a5/1", flit_o, is_valid_o); end
        flit_in = 32'h5A5A_5A5A;
        tick();
        checks++; if (flit_o !== 32'h5A5A_5A5A || is_valid_o !== 1'b1) begin errors++;
            $display("FAIL flit1 got %h/%b want 5a5a5a5a/1", flit_o, is_valid_o); end
        vin = 1'b0; flit_in = $urandom;
        tick();
        checks++; if (flit_o !== 32'h5A5A_5A5A || is_valid_o !== 1'b0) begin errors++;
            $display("FAIL flit_gap got %h/%b want 5a5a5a5a/0", flit_o, is_valid_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                g_ptr[i] = ($urandom_range(0, 3) == 0);
                rel[i]   = ($urandom_range(0, 3) == 0);
                cin[i]   = ($urandom_range(0, 1) == 0);
            end
            g_id    = 18'($urandom);
            vin     = $urandom_range(0, 1) == 1;
            flit_in = $urandom;
            tick();
            checks++; if (credit_signal_o !== e_credit) begin errors++;
                $display("FAIL rnd_credit c=%0d got %b want %b", c, credit_signal_o, e_credit); end
            checks++; if (vc_free_o !== e_free) begin errors++;
                $display("FAIL rnd_free c=%0d got %b want %b", c, vc_free_o, e_free); end
            checks++; if (err_o !== m_err) begin errors++;
                $display("FAIL rnd_err c=%0d got %b want %b", c, err_o, m_err); end
            checks++; if (flit_o !== e_flit || is_valid_o !== e_valid) begin errors++;
                $display("FAIL rnd_flit c=%0d got %h/%b want %h/%b", c, flit_o, is_valid_o,
                         e_flit, e_valid); end
            for (int i = 0; i < N; i++) begin
                if (e_credit[i]) begin
                    checks++;
                    if (fifo_pointed_o[i*W +: W] !== e_ptd[i]) begin errors++;
                        $display("FAIL rnd_pointed c=%0d vc=%0d got %0d want %0d", c, i,
                                 fifo_pointed_o[i*W +: W], e_ptd[i]); end
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        g_ptr = 6'b010010; g_id = 18'h0_7FFF;
        tick();
        clear_inputs();
        checks++; if (vc_free_o !== 6'b101101) begin errors++;
            $display("FAIL pre_async_free got %b want 101101", vc_free_o); end
        vin = 1'b1; flit_in = 32'hDEAD_BEEF;
        tick();
        cin = 6'b010010;
        #3;
        rst = 1'b0;
        #1;
        checks++; if (vc_free_o !== 6'b111111) begin errors++;
            $display("FAIL async_free got %b want 111111", vc_free_o); end
        checks++; if (is_valid_o !== 1'b0 || flit_o !== '0) begin errors++;
            $display("FAIL async_flit got %h/%b want 0/0", flit_o, is_valid_o); end
        checks++; if (err_o !== 1'b0 || credit_signal_o !== 6'b0) begin errors++;
            $display("FAIL async_err_credit got %b/%b want 0/0", err_o, credit_signal_o); end
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        checks++; if (vc_free_o !== 6'b111111 || credit_signal_o !== 6'b0) begin errors++;
            $display("FAIL post_reset got %b/%b want 111111/000000", vc_free_o,
                     credit_signal_o); end
    endtask

    initial begin
        test_reset();
        test_grant_credit();
        test_release_credit();
        test_realloc();
        test_flit();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
